// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: pipelined Kogge-Stone adder/subtractor with valid/ready flow control
module pipelined_prefix_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf
);
    localparam int L = $clog2(WIDTH);
    // prefix positions -1..WIDTH-1 live at indices 0..WIDTH; index 0 holds the carry-in
    localparam int N = WIDTH + 1;

    logic [L+1:0]            v;
    logic [L+1:0]            ld;
    logic [L:0][N-1:0]       g_q;
    logic [L:0][N-1:0]       p_q;
    logic [L:1][N-1:0]       gn;
    logic [L:1][N-1:0]       pn;
    logic [L:0][WIDTH-1:0]   po_q;
    logic [L:0]              am_q;
    logic [L:0]              bm_q;
    logic [WIDTH-1:0]        b;
    logic [WIDTH-1:0]        s_n;
    logic                    c_n;
    logic                    o_n;

    // a stage loads when it is empty or everything downstream of it can move
    for (genvar k = 0; k <= L + 1; k++) begin : g_ld
        assign ld[k] = out_ready || !(&v[L+1:k]);
    end

    assign in_ready  = ld[0] && !rst;
    assign out_valid = v[L+1];
    assign b         = Y ^ {WIDTH{sub}};

    // Kogge-Stone levels; positions whose partner falls below the carry-in pass through
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        for (genvar j = 0; j < N; j++) begin : g_pos
            if (j >= (1 << (k - 1))) begin : g_op
                assign gn[k][j] = g_q[k-1][j] | (p_q[k-1][j] & g_q[k-1][j-(1<<(k-1))]);
                assign pn[k][j] = p_q[k-1][j] & p_q[k-1][j-(1<<(k-1))];
            end else begin : g_pass
                assign gn[k][j] = g_q[k-1][j];
                assign pn[k][j] = p_q[k-1][j];
            end
        end
    end

    // c_out folds in the carry-in explicitly because for power-of-two widths the top group stops one short of it
    assign s_n = po_q[L] ^ g_q[L][WIDTH-1:0];
    assign c_n = g_q[L][WIDTH] | (p_q[L][WIDTH] & g_q[L][0]);
    assign o_n = (am_q[L] == bm_q[L]) && (s_n[WIDTH-1] != am_q[L]);

    // pipeline registers: each stage loads only when its enable allows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            g_q   <= '0;
            p_q   <= '0;
            po_q  <= '0;
            am_q  <= '0;
            bm_q  <= '0;
            S     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (ld[0]) begin
                v[0]    <= in_valid;
                g_q[0]  <= {X & b, c_in ^ sub};
                p_q[0]  <= {X ^ b, 1'b0};
                po_q[0] <= X ^ b;
                am_q[0] <= X[WIDTH-1];
                bm_q[0] <= b[WIDTH-1];
            end
            for (int k = 1; k <= L; k++) begin
                if (ld[k]) begin
                    v[k]    <= v[k-1];
                    g_q[k]  <= gn[k];
                    p_q[k]  <= pn[k];
                    po_q[k] <= po_q[k-1];
                    am_q[k] <= am_q[k-1];
                    bm_q[k] <= bm_q[k-1];
                end
            end
            if (ld[L+1]) begin
                v[L+1] <= v[L];
                S      <= s_n;
                c_out  <= c_n;
                ovf    <= o_n;
            end
        end
    end
endmodule
